// File: rtl/prg_port_arbiter.sv
// Two-requester arbiter for the CPU memory program port: turns single-word
// requests into ISSUE/WAIT/ACK port cycles. Optional macro: PRG_ARB_ROUND_ROBIN_EN.
module prg_port_arbiter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wd0,
   input  logic [7:0] wd1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rd0,
   output logic [7:0] rd1,
   output logic       busy,
   output logic       prg_clock,
   output logic       prg_we,
   output logic [7:0] prg_MA,
   output logic [7:0] prg_WD,
   input  logic [7:0] prg_RD
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t state, state_nxt;
   logic   ptr;
   logic   win;
   logic   we_l;
   logic   sel;

   assign prg_clock = clock;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      sel       = (req0 && req1) ? ptr : req1;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         win    <= 1'b0;
         we_l   <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rd0    <= 8'h00;
         rd1    <= 8'h00;
         prg_we <= 1'b0;
         prg_MA <= 8'h00;
         prg_WD <= 8'h00;
      end else begin
         state <= state_nxt;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         case (state)
            IDLE: if (req0 || req1) begin
               win    <= sel;
               we_l   <= sel ? we1 : we0;
               prg_we <= sel ? we1 : we0;
               prg_MA <= sel ? addr1 : addr0;
               prg_WD <= sel ? wd1 : wd0;
            end
            // write strobe lasts exactly the ISSUE cycle
            ISSUE: prg_we <= 1'b0;
            WAIT: begin
               if (!we_l) begin
                  if (win) rd1 <= prg_RD;
                  else     rd0 <= prg_RD;
               end
               ack0 <= ~win;
               ack1 <= win;
            end
            ACK: begin
`ifdef PRG_ARB_ROUND_ROBIN_EN
               ptr <= ~win;
`else
               ptr <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prg_port_arbiter.sv
// Bench for prg_port_arbiter: directed steps then randomized requests, checked
// against a word-level model (memory image, per-requester rd, priority rule).
module tb_prg_port_arbiter;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wd0 = 8'h00, wd1 = 8'h00;
   logic       ack0, ack1, busy, prg_clock, prg_we;
   logic [7:0] rd0, rd1, prg_MA, prg_WD;
   logic [7:0] prg_RD;

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];
   logic [7:0] rd_m    [2];
   bit         mptr;
   int         vectors = 0;
   int         errs = 0;

   prg_port_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
      .ack0(ack0), .ack1(ack1), .rd0(rd0), .rd1(rd1), .busy(busy),
      .prg_clock(prg_clock), .prg_we(prg_we), .prg_MA(prg_MA),
      .prg_WD(prg_WD), .prg_RD(prg_RD)
   );

   always #5 clock = ~clock;

   // synchronous program-port RAM: read data one cycle after the address
   always @(posedge clock) begin
      if (prg_we) ram[prg_MA] <= prg_WD;
      prg_RD <= ram[prg_MA];
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input bit w, input logic [7:0] a, input logic [7:0] d);
      if (r == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wd0 = d; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; end
   endtask

   task automatic drop(input int r);
      if (r == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   function automatic int pick();
      if (req0 && req1) return int'(mptr);
      return req1 ? 1 : 0;
   endfunction

   // Called at the falling edge of the IDLE cycle in which the request is sampled.
   task automatic expect_txn(input int who);
      logic       w;
      logic [7:0] a, d;
      w = (who == 1) ? we1 : we0;
      a = (who == 1) ? addr1 : addr0;
      d = (who == 1) ? wd1 : wd0;
      @(negedge clock);
      chk("issue_busy", busy, 8'd1);
      chk("issue_we", prg_we, w);
      chk("issue_ma", prg_MA, a);
      chk("issue_wd", prg_WD, d);
      chk("issue_ack", {ack1, ack0}, 8'd0);
      @(negedge clock);
      chk("wait_we", prg_we, 8'd0);
      chk("wait_busy", busy, 8'd1);
      @(negedge clock);
      if (w) ref_mem[a] = d;
      else   rd_m[who] = ref_mem[a];
      chk("ack0", ack0, (who == 0) ? 8'd1 : 8'd0);
      chk("ack1", ack1, (who == 1) ? 8'd1 : 8'd0);
      chk("rd0", rd0, rd_m[0]);
      chk("rd1", rd1, rd_m[1]);
      chk("ack_busy", busy, 8'd1);
`ifdef PRG_ARB_ROUND_ROBIN_EN
      mptr = (who == 0);
`else
      mptr = 1'b0;
`endif
      @(negedge clock);
      chk("idle_busy", busy, 8'd0);
      chk("idle_ack", {ack1, ack0}, 8'd0);
   endtask

   initial begin
      int e;
      for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
      rd_m[0] = 8'h00; rd_m[1] = 8'h00; mptr = 1'b0;

      repeat (2) @(negedge clock);
      chk("rst_ack", {ack1, ack0}, 8'd0);
      chk("rst_rd0", rd0, 8'h00);
      chk("rst_rd1", rd1, 8'h00);
      chk("rst_we", prg_we, 8'd0);
      chk("rst_ma", prg_MA, 8'h00);
      chk("rst_wd", prg_WD, 8'h00);
      chk("rst_busy", busy, 8'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // requester 0 write, then requester 1 read-back
      set_req(0, 1'b1, 8'h10, 8'h5A); expect_txn(pick()); drop(0);
      set_req(1, 1'b0, 8'h10, 8'h00); expect_txn(pick()); drop(1);
      chk("rd1_5a", rd1, 8'h5A);

      // simultaneous requests held high
      set_req(0, 1'b1, 8'h20, 8'h11);
      set_req(1, 1'b1, 8'h21, 8'h22);
      repeat (4) expect_txn(pick());
      drop(0); drop(1);

      // top address passes through
      set_req(1, 1'b1, 8'hFF, 8'hA5); expect_txn(pick()); drop(1);
      set_req(0, 1'b0, 8'hFF, 8'h00); expect_txn(pick()); drop(0);
      chk("rd0_ff", rd0, 8'hA5);

      // reset during ISSUE of a write
      set_req(0, 1'b1, 8'h30, 8'hEE);
      @(negedge clock);
      chk("abort_issue_we", prg_we, 8'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_we", prg_we, 8'd0);
      chk("abort_busy", busy, 8'd0);
      chk("abort_ma", prg_MA, 8'h00);
      chk("abort_rd0", rd0, 8'h00);
      drop(0);
      rd_m[0] = 8'h00; rd_m[1] = 8'h00; mptr = 1'b0;
      repeat (2) begin
         @(negedge clock);
         chk("abort_ack", {ack1, ack0}, 8'd0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_busy", busy, 8'd0);
      chk("post_rst_ack", {ack1, ack0}, 8'd0);

      // pointer back at 0: contention goes to requester 0
      set_req(0, 1'b0, 8'h30, 8'h00);
      set_req(1, 1'b0, 8'h10, 8'h00);
      expect_txn(pick()); drop(0);
      expect_txn(pick()); drop(1);
      chk("abort_no_write", rd0, 8'h00);

      // req0 held one cycle past ack: repeated transaction
      set_req(0, 1'b0, 8'h10, 8'h00);
      expect_txn(pick());
      expect_txn(pick());
      drop(0);

      // randomized single/dual requests
      repeat (40) begin
         e = int'($urandom_range(1, 3));
         if (e[0]) set_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         if (e[1]) set_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         while (req0 || req1) begin
            int who;
            who = pick();
            expect_txn(who);
            drop(who);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/prg_port_arbiter.md
# prg_port_arbiter

Shares the 8-bit program port of the CPU memory (the second RAM port used for loading and inspecting programs) between two requesters: the console monitor (requester 0) and the block loader (requester 1). It turns single-word read/write requests into correctly timed port cycles and returns read data with a one-cycle acknowledge. It sits between the monitor/loader logic and the memory's `prg_*` inputs, all in the `clock` domain.

## Interface

Parameters: none.

Ports:
- `clock`  in  1  system clock; also forwarded as `prg_clock`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request; held high until the matching `ack` is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr0`, `addr1`  in  8  word address; stable while `req` is high.
- `wd0`, `wd1`  in  8  write data; stable while `req` is high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rd0`, `rd1`  out  8  read data; updated only by read transactions and valid from the `ack` cycle onward.
- `busy`  out  1  high whenever the state machine is not in IDLE.
- `prg_clock`  out  1  equal to `clock`.
- `prg_we`  out  1  program-port write enable; registered.
- `prg_MA`  out  8  program-port address; registered.
- `prg_WD`  out  8  program-port write data; registered.
- `prg_RD`  in  8  program-port read data; valid one cycle after the address is captured.

## Operation

- Reset values: `ack0` = `ack1` = 0, `rd0` = `rd1` = 0x00, `prg_we` = 0, `prg_MA` = 0x00, `prg_WD` = 0x00, `busy` = 0, state IDLE, priority pointer = 0.
- States and transitions:
  - IDLE: if no request is pending, stay. Otherwise select a winner, latch its `we`/`addr`/`wd` into `prg_we`/`prg_MA`/`prg_WD`, and go to ISSUE.
  - ISSUE: drive the latched values for exactly one cycle, then go to WAIT.
  - WAIT: clear `prg_we`. On a read, capture `prg_RD` into the winner's `rd`. Go to ACK.
  - ACK: pulse the winner's `ack` for one cycle, update the priority pointer, and return to IDLE.
- Winner selection:
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester named by the priority pointer wins (see Configuration).
- A requester whose `req` rises while the other requester's transaction is in progress waits. It is not dropped.
- Write transactions leave the winner's `rd` unchanged and never touch the loser's `rd` or `ack`.
- All 256 addresses are passed through unchanged; there is no address filtering.
- The requester must drop `req` in the cycle after `ack`. If `req` is still high in the following IDLE cycle, it is treated as a new request.

## Timing

- Request sampled in IDLE at cycle N:
  - `prg_we`/`prg_MA`/`prg_WD` valid in cycle N+1.
  - `prg_we` is low again in cycle N+2.
  - `prg_RD` is sampled at the end of N+2.
  - `ack` and valid `rd` appear in N+3.
  - IDLE is re-entered in N+4.
- Fixed latency of 3 cycles from the sampled request to `ack`; maximum throughput is one transaction per 4 cycles.
- `busy` is high in cycles N+1 through N+3.
- A reset asserted mid-transaction immediately forces every output to its reset value, including dropping `prg_we` asynchronously. The aborted transaction is never acknowledged.

## Configuration

- `PRG_ARB_ROUND_ROBIN_EN` defined:
  - The pointer flips to the other requester after every completed grant.
  - With both requesters asserting continuously, grants alternate 0, 1, 0, 1.
- `PRG_ARB_ROUND_ROBIN_EN` not defined:
  - The pointer is held at 0, giving fixed priority to requester 0.
  - Requester 1 is granted only in IDLE cycles where `req0` is low.

## Test plan

- Reset, then requester 0 writes 0x5A to 0x10 → `prg_we` = 1 and `prg_MA` = 0x10 for exactly one cycle; `ack0` 3 cycles after sampling; `rd0` stays 0x00.
- Requester 1 reads 0x10 after that write → `ack1` at N+3 with `rd1` = 0x5A; `ack0` stays 0.
- `req0` and `req1` rise in the same cycle and stay high, requester 1 re-requesting after each ack:
  - with `PRG_ARB_ROUND_ROBIN_EN`: grant order 0, 1, 0, 1;
  - without it: requester 0 wins whenever `req0` is high in IDLE.
- Write 0xA5 to 0xFF, then read 0xFF via requester 0 → `rd0` = 0xA5, confirming no address filtering.
- Assert `reset_n` = 0 during ISSUE of a write → `prg_we` drops to 0 immediately, no `ack` is issued, and after release `busy` = 0 and the pointer = 0.
- Requester holds `req0` high for one cycle past `ack0` → a second, identical transaction is issued starting in the next IDLE cycle.
